// File: rtl/lockin_demod.sv
// Dual-phase lock-in demodulator: multiplies audio by DDFS cos/sin references,
// boxcar-integrates 2^N_LOG2 products and dumps the averaged I/Q pair.
// Optional build macro: LOCKIN_ROUND_EN (round-half-up on dump instead of truncation).
module lockin_demod #(
   parameter int unsigned AUDIO_W  = 24,
   parameter int unsigned LUT_BITS = 18,
   parameter int unsigned N_LOG2   = 10
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 run,
   input  logic                                 ref_valid,
   input  logic signed [LUT_BITS-1:0]           ref_cos,
   input  logic signed [LUT_BITS-1:0]           ref_sin,
   input  logic signed [AUDIO_W-1:0]            audio_in,
   output logic signed [AUDIO_W+LUT_BITS-1:0]   i_out,
   output logic signed [AUDIO_W+LUT_BITS-1:0]   q_out,
   output logic                                 out_valid,
   output logic                                 busy
);

   localparam int unsigned PW     = AUDIO_W + LUT_BITS;
   localparam int unsigned AW     = PW + N_LOG2;
   localparam int unsigned CNT_W  = (N_LOG2 == 0) ? 1 : N_LOG2;
   localparam int unsigned RND_SH = (N_LOG2 == 0) ? 0 : N_LOG2 - 1;

   localparam logic [CNT_W-1:0] CNT_LAST =
      (N_LOG2 == 0) ? '0 : CNT_W'((64'd1 << N_LOG2) - 64'd1);
   localparam logic signed [AW-1:0] RND =
      (N_LOG2 == 0) ? '0 : (AW'(1) << RND_SH);

   typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   v1_q, v1_d;
   logic signed [PW-1:0]   p_i_q, p_i_d, p_q_q, p_q_d;
   logic signed [AW-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   dump_q, dump_d;
   logic signed [PW-1:0]   i_out_q, i_out_d, q_out_q, q_out_d;
   logic                   out_valid_q, out_valid_d;
   logic                   busy_q, busy_d;
   logic signed [AW-1:0]   acc_i_rnd, acc_q_rnd;

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d     = state_q;
      v1_d        = 1'b0;
      p_i_d       = p_i_q;
      p_q_d       = p_q_q;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      cnt_d       = cnt_q;
      dump_d      = 1'b0;
      i_out_d     = i_out_q;
      q_out_d     = q_out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      acc_i_rnd   = acc_i_q;
      acc_q_rnd   = acc_q_q;

`ifdef LOCKIN_ROUND_EN
      acc_i_rnd = acc_i_q + RND;
      acc_q_rnd = acc_q_q + RND;
`endif

      state_d = run ? ACCUM : IDLE;
      busy_d  = run;

      // Stage 1: full-precision products, only while accumulating.
      if (ref_valid && run && (state_q == ACCUM)) begin
         v1_d  = 1'b1;
         p_i_d = PW'(audio_in) * PW'(ref_cos);
         p_q_d = PW'(audio_in) * PW'(ref_sin);
      end

      // Stage 2: a dropped run aborts the block and discards the in-flight product.
      if (!run) begin
         acc_i_d = '0;
         acc_q_d = '0;
         cnt_d   = '0;
      end else if (v1_q) begin
         if (cnt_q == '0) begin
            acc_i_d = AW'(p_i_q);
            acc_q_d = AW'(p_q_q);
         end else begin
            acc_i_d = acc_i_q + AW'(p_i_q);
            acc_q_d = acc_q_q + AW'(p_q_q);
         end
         cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
         dump_d = (cnt_q == CNT_LAST);
      end

      // Dump reads the finished accumulator while the next block loads over it.
      if (run && dump_q) begin
         i_out_d     = PW'(acc_i_rnd >>> N_LOG2);
         q_out_d     = PW'(acc_q_rnd >>> N_LOG2);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         v1_q        <= 1'b0;
         p_i_q       <= '0;
         p_q_q       <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         dump_q      <= 1'b0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         v1_q        <= v1_d;
         p_i_q       <= p_i_d;
         p_q_q       <= p_q_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         cnt_q       <= cnt_d;
         dump_q      <= dump_d;
         i_out_q     <= i_out_d;
         q_out_q     <= q_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule
